// File: rtl/fc_fm_packer.sv
// Requantizes the flattened conv/pool activation stream to int8, packs 8 lanes per
// 64-bit word into the FC feature-map SRAM and launches the FC stage when done.
module fc_fm_packer #(
  parameter int IN_W     = 21,
  parameter int SHIFT    = 4,
  parameter int NUM_ELEM = 384,
  parameter int RELU_EN  = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_pk_start,
  input  logic [8:0]             i_pk_base_addr,
  input  logic                   i_pk_valid,
  input  logic signed [IN_W-1:0] i_pk_data,
  output logic                   o_pk_ready,
  output logic                   o_pk_wr_en,
  output logic [15:0]            o_pk_wr_addr,
  output logic [63:0]            o_pk_wr_data,
  output logic                   o_pk_busy,
  output logic                   o_pk_done,
  output logic                   o_fc_start
);

  localparam int CNT_W = $clog2(NUM_ELEM + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PACK,
    S_FLUSH,
    S_WLAST,
    S_DONE
  } state_t;

  state_t state, next_state;

  logic [8:0]             base;
  logic [CNT_W-1:0]       elem_cnt;
  logic [2:0]             lane;
  logic [15:0]            word_idx;
  logic [63:0]            pack_reg;
  logic signed [IN_W-1:0] shifted;
  logic [7:0]             q8;
  logic [63:0]            merged;
  logic                   accept;
  logic                   last_elem;

  assign accept    = i_pk_valid && o_pk_ready;
  assign last_elem = (elem_cnt == CNT_W'(NUM_ELEM - 1));
  assign shifted   = i_pk_data >>> SHIFT;

  always_comb begin
    q8 = shifted[7:0];
    if (shifted > IN_W'(127)) begin
      q8 = 8'h7F;
    end else if (shifted < IN_W'(-128)) begin
      q8 = 8'h80;
    end
    if (RELU_EN != 0 && q8[7]) begin
      q8 = 8'h00;
    end
  end

  // Lanes fill in order from a cleared register, so unused upper lanes stay zero.
  assign merged = pack_reg | ({56'b0, q8} << {lane, 3'b000});

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (i_pk_start) next_state = S_PACK;
      S_PACK: begin
        if (accept && last_elem) begin
          next_state = (lane == 3'd7) ? S_WLAST : S_FLUSH;
        end
      end
      S_FLUSH: next_state = S_DONE;
      S_WLAST: next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Completed words go straight to the write register, so a new lane-0 accept
  // in the same cycle can never disturb the word being written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      base         <= '0;
      elem_cnt     <= '0;
      lane         <= '0;
      word_idx     <= '0;
      pack_reg     <= '0;
      o_pk_ready   <= 1'b0;
      o_pk_wr_en   <= 1'b0;
      o_pk_wr_addr <= '0;
      o_pk_wr_data <= '0;
      o_pk_busy    <= 1'b0;
      o_pk_done    <= 1'b0;
      o_fc_start   <= 1'b0;
    end else begin
      state      <= next_state;
      o_pk_ready <= (next_state == S_PACK);
      o_pk_busy  <= (next_state != S_IDLE);
      o_pk_done  <= (next_state == S_DONE);
      o_fc_start <= (next_state == S_DONE);
      o_pk_wr_en <= 1'b0;
      if (state == S_IDLE && i_pk_start) begin
        base     <= i_pk_base_addr;
        elem_cnt <= '0;
        lane     <= '0;
        word_idx <= '0;
        pack_reg <= '0;
      end
      if (accept) begin
        elem_cnt <= elem_cnt + CNT_W'(1);
        lane     <= lane + 3'd1;
        if (lane == 3'd7 || last_elem) begin
          o_pk_wr_en   <= 1'b1;
          o_pk_wr_addr <= {7'b0, base} + word_idx;
          o_pk_wr_data <= merged;
          word_idx     <= word_idx + 16'd1;
          pack_reg     <= '0;
        end else begin
          pack_reg <= merged;
        end
      end
    end
  end

endmodule
